// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, ALU operation codes and the decoded control bundle.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXE_R    = 4'd2,
    ST_R_WB     = 4'd3,
    ST_EXE_I    = 4'd4,
    ST_I_WB     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALUOp 0 is reserved so a held-in-reset unit is distinguishable from ADDU
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_ADD  = 5'd2;
  localparam logic [4:0] ALUOp_SUBU = 5'd3;
  localparam logic [4:0] ALUOp_SLT  = 5'd4;
  localparam logic [4:0] ALUOp_OR   = 5'd5;
  localparam logic [4:0] ALUOp_SLL  = 5'd6;
  localparam logic [4:0] ALUOp_ADDI = 5'd7;
  localparam logic [4:0] ALUOp_BEQ  = 5'd8;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  // First execution state for an instruction; ST_FETCH marks an illegal encoding.
  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUBU, FN_SLT, FN_OR, FN_SLL: return ST_EXE_R;
          default: return ST_FETCH;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ORI: return ST_EXE_I;
      OP_LW, OP_SW:              return ST_MEM_ADDR;
      OP_BEQ:                    return ST_BRANCH;
      OP_J:                      return ST_JUMP;
      default:                   return ST_FETCH;
    endcase
  endfunction

  function automatic logic [4:0] r_alu_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALUOp_ADD;
      FN_SUBU: return ALUOp_SUBU;
      FN_SLT:  return ALUOp_SLT;
      FN_OR:   return ALUOp_OR;
      FN_SLL:  return ALUOp_SLL;
      default: return ALUOp_ADDU;
    endcase
  endfunction

  function automatic logic [4:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDI: return ALUOp_ADDI;
      OP_ORI:  return ALUOp_OR;
      default: return ALUOp_ADDU;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: maps the current state plus IR fields,
// Zero and the memory handshake onto the datapath control bundle.
module mc_ctrl_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output ctl_t       ctl
);

  always_comb begin
    ctl        = '0;
    ctl.alu_op = ALUOp_ADDU;
    case (state)
      ST_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'd1;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // branch target is computed speculatively into ALUOut
        ctl.alu_src_b = 2'd3;
        ctl.ext_op    = 1'b1;
        ctl.alu_op    = ALUOp_ADD;
        if (dispatch(op, funct) == ST_FETCH) begin
          ctl.illegal    = 1'b1;
          ctl.instr_done = 1'b1;
        end
      end
      ST_EXE_R: begin
        ctl.alu_src_a = (funct == FN_SLL) ? 2'd2 : 2'd1;
        ctl.alu_op    = r_alu_op(funct);
      end
      ST_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_EXE_I: begin
        ctl.alu_src_a = 2'd1;
        ctl.alu_src_b = 2'd2;
        ctl.ext_op    = (op != OP_ORI);
        ctl.alu_op    = i_alu_op(op);
      end
      ST_I_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctl.alu_src_a = 2'd1;
        ctl.alu_src_b = 2'd2;
        ctl.ext_op    = 1'b1;
        ctl.alu_op    = ALUOp_ADD;
      end
      ST_MEM_RD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctl.iord       = 1'b1;
        ctl.mem_write  = 1'b1;
        ctl.instr_done = mem_ready;
      end
      ST_BRANCH: begin
        ctl.alu_src_a  = 2'd1;
        ctl.alu_op     = ALUOp_BEQ;
        ctl.pc_source  = 2'd1;
        ctl.pc_write   = Zero;
        ctl.instr_done = 1'b1;
      end
      ST_JUMP: begin
        ctl.pc_source  = 2'd2;
        ctl.pc_write   = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: state register and next-state logic, with
// output decode delegated to mc_ctrl_decode and forced to zero during reset.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE    | dispatch on op/funct, branch target -> ALUOut
// EXE_R     | R-type ALU operation
// R_WB      | write ALUOut to rd
// EXE_I     | immediate ALU operation
// I_WB      | write ALUOut to rt
// MEM_ADDR  | load/store effective address
// MEM_RD    | data read, waits for mem_ready
// MEM_WB    | write MDR to rt
// MEM_WR    | data write, waits for mem_ready
// BRANCH    | beq compare, PC <- ALUOut when Zero
// JUMP      | PC <- jump target
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [4:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal
);

  logic [ST_W-1:0] state_q;
  state_t          state;
  state_t          state_d;
  ctl_t            ctl;
  ctl_t            ctl_g;

  assign state = state_t'(state_q);

  always_comb begin
    state_d = state;
    case (state)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:   state_d = dispatch(op, funct);
      ST_EXE_R:    state_d = ST_R_WB;
      ST_EXE_I:    state_d = ST_I_WB;
      ST_MEM_ADDR: state_d = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_W'(ST_FETCH);
    else     state_q <= ST_W'(state_d);
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .op        (op),
    .funct     (funct),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  // The register may still hold a mid-instruction state in the first reset cycle
  assign ctl_g = rst ? '0 : ctl;

  assign ALUOp      = ctl_g.alu_op;
  assign ALUSrcA    = ctl_g.alu_src_a;
  assign ALUSrcB    = ctl_g.alu_src_b;
  assign ExtOp      = ctl_g.ext_op;
  assign IorD       = ctl_g.iord;
  assign MemRead    = ctl_g.mem_read;
  assign MemWrite   = ctl_g.mem_write;
  assign IRWrite    = ctl_g.ir_write;
  assign RegWrite   = ctl_g.reg_write;
  assign RegDst     = ctl_g.reg_dst;
  assign MemtoReg   = ctl_g.mem_to_reg;
  assign PCWrite    = ctl_g.pc_write;
  assign PCSource   = ctl_g.pc_source;
  assign instr_done = ctl_g.instr_done;
  assign illegal    = ctl_g.illegal;

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle MIPS control unit that sits directly upstream of the ALU (`alu_32`). It sequences each instruction through fetch, decode, execute, memory and writeback states. In every state it drives the ALU operation code, the datapath mux selects and the register/memory/PC write strobes. It samples the ALU `Zero` flag to resolve `beq`, and waits on a memory-ready handshake for instruction and data accesses.

## Interface
Parameters:
- `ST_W`, 4, width of state register

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `op`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `Zero`  in  1  ALU flag (`C[0]`)
- `mem_ready`  in  1  memory completes the current access this cycle
- `ALUOp`  out  5  ALU operation, `ALUOp_*` codes
- `ALUSrcA`  out  2  0=PC, 1=reg A, 2=shamt (zero-extended IR[10:6])
- `ALUSrcB`  out  2  0=reg B, 1=const 4, 2=ext imm, 3=ext imm<<2
- `ExtOp`  out  1  1=sign-extend imm, 0=zero-extend
- `IorD`  out  1  0=PC address, 1=ALUOut address
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`  out  1 each  strobes
- `RegDst`  out  1  1=rd, 0=rt
- `MemtoReg`  out  1  1=MDR, 0=ALUOut
- `PCWrite`  out  1  PC update enable (unconditional or taken branch)
- `PCSource`  out  2  0=ALU result, 1=ALUOut, 2=jump target
- `instr_done`  out  1  one-cycle pulse on the last cycle of an instruction
- `illegal`  out  1  one-cycle pulse in DECODE on an unsupported op/funct

## Operation
- Supported R-type (op=0) funct values:
  - `add` 0x20 → ALUOp_ADD
  - `addu` 0x21 → ALUOp_ADDU
  - `subu` 0x23 → ALUOp_SUBU
  - `slt` 0x2A → ALUOp_SLT
  - `or` 0x25 → ALUOp_OR
  - `sll` 0x00 → ALUOp_SLL, with ALUSrcA=2
- Supported I/J types:
  - `addi` 0x08 → ALUOp_ADDI, sign-extended
  - `addiu` 0x09 → ALUOp_ADDU, sign-extended
  - `ori` 0x0D → ALUOp_OR, zero-extended
  - `lw` 0x23 and `sw` 0x2B → address calculation with ALUOp_ADD
  - `beq` 0x04 → ALUOp_BEQ
  - `j` 0x02
- States and their actions/transitions:
  - FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp_ADDU, PCSource=0. Holds while `mem_ready`=0. On `mem_ready`=1: IRWrite=1, PCWrite=1, then go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUOp_ADD (branch target into ALUOut). Dispatches on op/funct. On an illegal op or funct: pulse `illegal` and `instr_done`, then go to FETCH.
  - EXE_R: R-type operation → R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done → FETCH.
  - EXE_I: ALUSrcA=1, ALUSrcB=2 → I_WB.
  - I_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done → FETCH.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp_ADD → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: IorD=1, MemRead=1. Holds until `mem_ready`, then → MEM_WB.
  - MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done → FETCH.
  - MEM_WR: IorD=1, MemWrite=1. Holds until `mem_ready`, then instr_done → FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp_BEQ, PCSource=1. PCWrite=`Zero` (combinational). instr_done → FETCH.
  - JUMP: PCSource=2, PCWrite=1, instr_done → FETCH.
- Outputs are a combinational decode of the state register plus `op`/`funct`. Any output not listed for a state is 0.
- `ALUOp` defaults to ALUOp_ADDU in every state where the ALU result is unused.

## Timing
- While `rst`=1:
  - All strobes are 0: MemRead, MemWrite, IRWrite, RegWrite, PCWrite, instr_done, illegal.
  - All selects and ALUOp are 0.
  - State is FETCH.
- First FETCH access occurs in the cycle after `rst` deasserts.
- Reset mid-instruction: the state returns to FETCH at the next edge. No write strobe is asserted during any cycle in which `rst`=1.
- Latency with `mem_ready` tied high:
  - R-type: 4 cycles
  - I-ALU: 4 cycles
  - `lw`: 5 cycles
  - `sw`: 4 cycles
  - `beq`: 3 cycles
  - `j`: 3 cycles
  - illegal: 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle. During that cycle all strobes except MemRead/MemWrite are held 0.
- `instr_done` is asserted exactly once per instruction.

## Structure
- State encodings (`ST_*`) and opcode/funct constants (`OP_*`, `FN_*`) go in the shared header `ctrl_encode_def.v`, next to the existing `ALUOp_*` codes.
- Split into two pieces:
  - the state register and next-state logic in `mc_ctrl_fsm`;
  - output decode in one sub-module, `mc_ctrl_decode`, which is purely combinational over (state, op, funct, Zero).

## Test plan
- Reset held for 3 cycles during MEM_WR with `mem_ready`=1 → MemWrite=0 throughout. FETCH with MemRead=1 appears one cycle after release.
- `add` (op=0, funct=0x20), `mem_ready`=1 → state sequence FETCH, DECODE, EXE_R, R_WB. R_WB has RegWrite=1, RegDst=1. `instr_done` pulses once, on cycle 4.
- `lw` with `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total. MemtoReg=1 and RegWrite=1 only in the final cycle.
- `beq` with Zero=1, then again with Zero=0 → PCWrite=1 vs 0 in the BRANCH cycle. PCSource=1 and ALUOp=ALUOp_BEQ in both cases.
- `sll` (funct=0x00) → ALUSrcA=2 and ALUOp=ALUOp_SLL in EXE_R. `ori` (op=0x0D) → ExtOp=0 and ALUOp=ALUOp_OR in EXE_I.
- op=0x3F → `illegal` and `instr_done` pulse in DECODE. The next cycle is FETCH. No RegWrite, MemWrite or PCWrite occurs.
